// File: rtl/wave_gen_pkg.sv
// Shared types for the wave generator: waveform mode, count direction and reset mode.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    TRIANGLE = 2'd0,
    SAW_UP   = 2'd1,
    SAW_DOWN = 2'd2,
    SQUARE   = 2'd3
  } mode_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  localparam mode_t MODE_DEFAULT = TRIANGLE;

endpackage

// File: rtl/wave_step_unit.sv
// Combinational next-sample computation: one clamped step of the counter and its direction.
// Sums and differences are formed in N+1 bits so an overflow or borrow clamps instead of wrapping.
module wave_step_unit
  import wave_gen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] cnt_i,
  input  dir_t         dir_i,
  input  logic [N-1:0] lo_i,
  input  logic [N-1:0] hi_i,
  input  logic [N-1:0] step_i,
  input  mode_t        mode_i,
  output logic [N-1:0] cnt_o,
  output dir_t         dir_o
);

  logic [N:0] sum;
  logic [N:0] diff;
  logic       reach_hi;
  logic       reach_lo;

  assign sum      = {1'b0, cnt_i} + {1'b0, step_i};
  assign diff     = {1'b0, cnt_i} - {1'b0, step_i};
  assign reach_hi = (sum >= {1'b0, hi_i});
  // A borrow out of the top bit means the true difference is negative, hence below lo.
  assign reach_lo = diff[N] || (diff[N-1:0] <= lo_i);

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    cnt_o = cnt_i;
    dir_o = dir_i;
    case (mode_i)
      SAW_UP: begin
        dir_o = UP;
        if (cnt_i == hi_i)  cnt_o = lo_i;
        else if (reach_hi)  cnt_o = hi_i;
        else                cnt_o = sum[N-1:0];
      end
      SAW_DOWN: begin
        dir_o = UP;
        if (cnt_i == lo_i)  cnt_o = hi_i;
        else if (reach_lo)  cnt_o = lo_i;
        else                cnt_o = diff[N-1:0];
      end
      default: begin
        if (dir_i == UP) begin
          if (reach_hi) begin
            cnt_o = hi_i;
            dir_o = DOWN;
          end else begin
            cnt_o = sum[N-1:0];
          end
        end else begin
          if (reach_lo) begin
            cnt_o = lo_i;
            dir_o = UP;
          end else begin
            cnt_o = diff[N-1:0];
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/wave_generator.sv
// Multi-mode waveform generator with a shadowed, validated runtime configuration applied at a period boundary.
// Optional half-period marker output peak is built only when WAVE_GEN_PEAK_EN is defined.
module wave_generator
  import wave_gen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [1:0]   cfg_mode,
  input  logic [N-1:0] cfg_lo,
  input  logic [N-1:0] cfg_hi,
  input  logic [N-1:0] cfg_step,
  output logic         cfg_err,
  output logic         wrap,
`ifdef WAVE_GEN_PEAK_EN
  output logic         peak,
`endif
  output logic [N-1:0] out
);

  mode_t        mode_q, mode_d, sh_mode_q, sh_mode_d;
  logic [N-1:0] lo_q, lo_d, sh_lo_q, sh_lo_d;
  logic [N-1:0] hi_q, hi_d, sh_hi_q, sh_hi_d;
  logic [N-1:0] step_q, step_d, sh_step_q, sh_step_d;
  logic [N-1:0] cnt_q, cnt_d;
  dir_t         dir_q, dir_d;
  logic         pending_q, pending_d;
  logic         err_q, err_d;

  logic [N-1:0] step_cnt;
  dir_t         step_dir;
  logic         accept;
  logic         cfg_ok;
  logic         at_start_nxt;
  logic         apply;

  function automatic logic [N-1:0] start_value(input mode_t m, input logic [N-1:0] lo,
                                               input logic [N-1:0] hi);
    return (m == SAW_DOWN) ? hi : lo;
  endfunction

  wave_step_unit #(.N(N)) u_step (
    .cnt_i  (cnt_q),
    .dir_i  (dir_q),
    .lo_i   (lo_q),
    .hi_i   (hi_q),
    .step_i (step_q),
    .mode_i (mode_q),
    .cnt_o  (step_cnt),
    .dir_o  (step_dir)
  );

  assign accept = cfg_valid && cfg_ready;
  assign cfg_ok = (cfg_lo < cfg_hi) && (cfg_step != '0) && (cfg_step <= cfg_hi - cfg_lo);

  // A pending config lands where the old waveform would restart anyway, or immediately when idle.
  assign at_start_nxt = (mode_q == SAW_DOWN) ? (step_cnt == hi_q)
                                             : ((step_cnt == lo_q) && (step_dir == UP));
  assign apply        = pending_q && (!ena || at_start_nxt);

  always_comb begin
    mode_d    = mode_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    sh_mode_d = sh_mode_q;
    sh_lo_d   = sh_lo_q;
    sh_hi_d   = sh_hi_q;
    sh_step_d = sh_step_q;
    pending_d = pending_q;
    err_d     = 1'b0;

    if (accept) begin
      sh_mode_d = mode_t'(cfg_mode);
      sh_lo_d   = cfg_lo;
      sh_hi_d   = cfg_hi;
      sh_step_d = cfg_step;
      pending_d = cfg_ok;
      err_d     = !cfg_ok;
    end

    if (apply) begin
      mode_d    = sh_mode_q;
      lo_d      = sh_lo_q;
      hi_d      = sh_hi_q;
      step_d    = sh_step_q;
      cnt_d     = start_value(sh_mode_q, sh_lo_q, sh_hi_q);
      dir_d     = UP;
      pending_d = 1'b0;
    end else if (ena) begin
      cnt_d = step_cnt;
      dir_d = step_dir;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_DEFAULT;
      lo_q      <= '0;
      hi_q      <= '1;
      step_q    <= N'(1);
      cnt_q     <= '0;
      dir_q     <= UP;
      sh_mode_q <= MODE_DEFAULT;
      sh_lo_q   <= '0;
      sh_hi_q   <= '1;
      sh_step_q <= N'(1);
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      sh_mode_q <= sh_mode_d;
      sh_lo_q   <= sh_lo_d;
      sh_hi_q   <= sh_hi_d;
      sh_step_q <= sh_step_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready = !pending_q;
  assign cfg_err   = err_q;
  assign wrap      = ena && (dir_q == UP) && (cnt_q == start_value(mode_q, lo_q, hi_q));
  assign out       = (mode_q == SQUARE) ? ((dir_q == UP) ? hi_q : lo_q) : cnt_q;

`ifdef WAVE_GEN_PEAK_EN
  assign peak = ena && (cnt_q == ((mode_q == SAW_DOWN) ? lo_q : hi_q));
`endif

endmodule

// File: tb/tb_wave_generator.sv
// Scoreboard bench for wave_generator: a behavioural model queues the expected outputs of each
// cycle as stimulus is driven; a negedge monitor pops and compares them, plus literal sample sequences.
module tb_wave_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_lo;
  logic [7:0] cfg_hi;
  logic [7:0] cfg_step;
  logic       cfg_err;
  logic       wrap;
  logic [7:0] out;
`ifdef WAVE_GEN_PEAK_EN
  logic       peak;
`endif

  wave_generator #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .cfg_step  (cfg_step),
    .cfg_err   (cfg_err),
    .wrap      (wrap),
`ifdef WAVE_GEN_PEAK_EN
    .peak      (peak),
`endif
    .out       (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       wrap;
    logic       ready;
    logic       err;
    logic       peak;
    int         lit;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Behavioural reference state (plain integers, unbounded arithmetic then clamped).
  int m_mode, m_lo, m_hi, m_step, m_cnt;
  int s_mode, s_lo, s_hi, s_step;
  bit m_up, m_pend, m_err;

  int saw[5]  = '{10, 13, 16, 19, 20};
  int tri3[6] = '{0, 1, 2, 3, 2, 1};
  int sdn[5]  = '{9, 7, 5, 3, 2};
  int sup[3]  = '{0, 200, 255};
  int sdf[3]  = '{255, 55, 0};
  int tbg[4]  = '{0, 200, 255, 55};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int start_of(input int md, input int lo, input int hi);
    return (md == 2) ? hi : lo;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_lo = 0; m_hi = 255; m_step = 1;
    m_cnt  = 0; m_up = 1'b1; m_pend = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit en, input bit v,
                            input int md, input int lo, input int hi, input int st);
    int c;
    bit u, acc, ok, bnd;
    if (r) begin
      model_reset();
      return;
    end
    c = m_cnt;
    u = m_up;
    case (m_mode)
      1: c = (m_cnt == m_hi) ? m_lo : ((m_cnt + m_step > m_hi) ? m_hi : m_cnt + m_step);
      2: c = (m_cnt == m_lo) ? m_hi : ((m_cnt - m_step < m_lo) ? m_lo : m_cnt - m_step);
      default: begin
        if (m_up) begin
          c = m_cnt + m_step;
          if (c >= m_hi) begin c = m_hi; u = 1'b0; end
        end else begin
          c = m_cnt - m_step;
          if (c <= m_lo) begin c = m_lo; u = 1'b1; end
        end
      end
    endcase
    bnd   = (m_mode == 2) ? (c == m_hi) : (c == m_lo && u);
    acc   = v && !m_pend;
    ok    = (lo < hi) && (st != 0) && (st <= hi - lo);
    m_err = acc && !ok;
    if (m_pend && (!en || bnd)) begin
      m_mode = s_mode; m_lo = s_lo; m_hi = s_hi; m_step = s_step;
      m_cnt  = start_of(s_mode, s_lo, s_hi);
      m_up   = 1'b1;
      m_pend = 1'b0;
    end else if (en) begin
      m_cnt = c;
      m_up  = u;
    end
    if (acc) begin
      s_mode = md; s_lo = lo; s_hi = hi; s_step = st;
      m_pend = ok;
    end
  endtask

  // One clock cycle: drive inputs for the coming edge, queue what the current state must show.
  task automatic drive(input bit en, input int lit = -1, input bit v = 1'b0, input int md = 0,
                       input int lo = 0, input int hi = 0, input int st = 0, input bit r = 1'b0);
    exp_t e;
    int   o;
    @(posedge clk);
    #1;
    rst       = r;
    ena       = en;
    cfg_valid = v;
    cfg_mode  = md[1:0];
    cfg_lo    = lo[7:0];
    cfg_hi    = hi[7:0];
    cfg_step  = st[7:0];
    o       = (m_mode == 3) ? (m_up ? m_hi : m_lo) : m_cnt;
    e.out   = o[7:0];
    e.wrap  = en && m_up && (m_cnt == start_of(m_mode, m_lo, m_hi));
    e.ready = !m_pend;
    e.err   = m_err;
    e.peak  = en && (m_cnt == ((m_mode == 2) ? m_lo : m_hi));
    e.lit   = lit;
    sb.push_back(e);
    model_edge(r, en, v, md, lo, hi, st);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      check("out", out, mon_e.out);
      check("wrap", wrap, mon_e.wrap);
      check("cfg_ready", cfg_ready, mon_e.ready);
      check("cfg_err", cfg_err, mon_e.err);
      if (mon_e.lit >= 0) check("out_seq", out, mon_e.lit);
`ifdef WAVE_GEN_PEAK_EN
      check("peak", peak, mon_e.peak);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; ena = 1'b0; cfg_valid = 1'b0;
    cfg_mode = '0; cfg_lo = '0; cfg_hi = '0; cfg_step = '0;
    repeat (3) @(posedge clk);
    model_reset();

    // Default full-range triangle, including both peaks and the return through 0.
    for (int i = 0; i < 512; i++)
      drive(1'b1, (i <= 255) ? i : ((i <= 510) ? 510 - i : i - 510));

    // SAW_UP 10..20 step 3, offered mid-period; must wait for the old triangle to restart.
    drive(1'b1, 2, 1'b1, 1, 10, 20, 3);
    n = 0;
    while (m_mode != 1 && n < 600) begin
      drive(1'b1);
      n++;
    end
    check("saw_apply_bound", n < 600, 1);
    for (int k = 0; k < 11; k++) drive(1'b1, saw[k % 5]);

    // Invalid configs: lo==hi, then step wider than the range; waveform must carry on.
    drive(1'b1, 13, 1'b1, 0, 5, 5, 1);
    drive(1'b1, 16);
    drive(1'b1, 19, 1'b1, 1, 10, 20, 11);
    drive(1'b1, 20);
    drive(1'b1, 10);

    // Accept TRIANGLE 0..3, keep cfg_valid high with another config while pending, apply via ena=0.
    drive(1'b1, 13, 1'b1, 0, 0, 3, 1);
    drive(1'b1, 16, 1'b1, 2, 0, 3, 1);
    drive(1'b1, 19, 1'b1, 2, 0, 3, 1);
    drive(1'b0, 20);
    for (int k = 0; k < 14; k++) drive(1'b1, tri3[k % 6]);

    // SQUARE 0..200 step 50: four samples high, four low.
    drive(1'b1, 2, 1'b1, 3, 0, 200, 50);
    n = 0;
    while (m_mode != 3 && n < 20) begin
      drive(1'b1);
      n++;
    end
    check("square_apply_bound", n < 20, 1);
    for (int k = 0; k < 16; k++) drive(1'b1, ((k % 8) < 4) ? 200 : 0);

    // Reset while a config is pending: the pending config must not survive an idle edge.
    drive(1'b1, -1, 1'b1, 2, 50, 100, 7);
    drive(1'b1, -1, 1'b0, 0, 0, 0, 0, 1'b1);
    drive(1'b0, 0);
    drive(1'b1, 0);
    drive(1'b1, 1);
    drive(1'b1, 2);

    // SAW_DOWN 2..9 step 2: last step clamps at lo.
    drive(1'b0, 3, 1'b1, 2, 2, 9, 2);
    drive(1'b0, 3);
    for (int k = 0; k < 12; k++) drive(1'b1, sdn[k % 5]);

    // Full-range saws and triangle with a large step: clamping must hide any 8-bit wrap.
    drive(1'b0, -1, 1'b1, 1, 0, 255, 200);
    drive(1'b0);
    for (int k = 0; k < 6; k++) drive(1'b1, sup[k % 3]);
    drive(1'b0, -1, 1'b1, 2, 0, 255, 200);
    drive(1'b0);
    for (int k = 0; k < 6; k++) drive(1'b1, sdf[k % 3]);
    drive(1'b0, -1, 1'b1, 0, 0, 255, 200);
    drive(1'b0);
    for (int k = 0; k < 8; k++) drive(1'b1, tbg[k % 4]);

    drive(1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
